// File: rtl/dll_cmd_issue.sv
// dll_cmd_issue: command front-end for the doubly linked list.
// Checks each command against the list status flags. Legal commands go out as
// single-cycle cmd_pass strobes and illegal ones are answered with an error.
// Every accepted command gets exactly one response, in acceptance order.
// A small response FIFO with a registered head entry holds the responses.
// The block also sequences the clear-all operation with the list.
module dll_cmd_issue #(
    parameter int RSP_DEPTH = 2,
    parameter int OP_W      = 2,
    parameter int ID_W      = 2,
    parameter int DATA_W    = 8,
    parameter int OP_PUSH_B = 1,
    parameter int N_LISTS   = 1 << ID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ID_W-1:0]   in_id,
    input  logic [DATA_W-1:0] in_data,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              clear_req,
    output logic              clear_ack,
    output logic              cmd_pass,
    output logic [OP_W-1:0]   cmd_op,
    output logic [ID_W-1:0]   cmd_id,
    output logic [DATA_W-1:0] cmd_push_data,
    input  logic [DATA_W-1:0] cmd_pop_data,
    input  logic              cmd_pop_data_vld_r,
    output logic              clear,
    input  logic              full_r,
    input  logic [N_LISTS-1:0] nempty_r,
    input  logic              busy_r
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int BUF_D = RSP_DEPTH - 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLR   = 2'd2,
        ST_WAITB = 2'd3
    } state_t;

    // Each FIFO entry is {err, data}.
    state_t              state_q, state_d;
    logic                gap_q, gap_d;
    logic                inflight_q, inflight_d;
    logic                clear_q, clear_d;
    logic                clear_ack_q, clear_ack_d;
    logic                head_vld_q, head_vld_d;
    logic [DATA_W:0]     head_ent_q, head_ent_d;
    logic [DATA_W:0]     buf_q [BUF_D];
    logic [DATA_W:0]     buf_d [BUF_D];
    logic [CNT_W-1:0]    buf_cnt_q, buf_cnt_d;

    logic [SUM_W-1:0]    used_s;
    logic                in_rdy_s;
    logic                acc_s;
    logic                is_push_s;
    logic                reject_s;
    logic                pass_s;
    logic                pop_ret_s;
    logic                enq_s;
    logic [DATA_W:0]     enq_ent_s;
    logic                deq_s;
    logic                buf_pop_s;
    logic                enq_to_buf_s;
    logic [CNT_W-1:0]    wr_idx_s;

    // Acceptance, legality check and response source selection.
    always_comb begin
        used_s    = SUM_W'(head_vld_q) + SUM_W'(buf_cnt_q) + SUM_W'(inflight_q);
        in_rdy_s  = !rst && (state_q == ST_RUN) && !busy_r && !gap_q &&
                    (used_s < SUM_W'(RSP_DEPTH)) && !clear_req;
        acc_s     = in_vld && in_rdy_s;
        is_push_s = in_op[OP_PUSH_B];
        if (is_push_s) begin
            reject_s = acc_s && full_r;
        end else begin
            reject_s = acc_s && !nempty_r[in_id];
        end
        pass_s    = acc_s && !reject_s;
        // Pop data is only honoured while a pop is really outstanding.
        pop_ret_s = cmd_pop_data_vld_r && inflight_q;
        enq_s     = (acc_s && (reject_s || is_push_s)) || pop_ret_s;
        if (pop_ret_s) begin
            enq_ent_s = {1'b0, cmd_pop_data};
        end else begin
            enq_ent_s = {reject_s, {DATA_W{1'b0}}};
        end
        gap_d = pass_s;
        if (pass_s && !is_push_s) begin
            inflight_d = 1'b1;
        end else if (pop_ret_s) begin
            inflight_d = 1'b0;
        end else begin
            inflight_d = inflight_q;
        end
    end

    // Response FIFO: refill the registered head first, overflow into the buffer.
    always_comb begin
        head_vld_d   = head_vld_q;
        head_ent_d   = head_ent_q;
        buf_d        = buf_q;
        buf_pop_s    = 1'b0;
        enq_to_buf_s = 1'b0;
        deq_s        = head_vld_q && rsp_rdy;
        if (!head_vld_q || deq_s) begin
            if (buf_cnt_q != '0) begin
                head_vld_d   = 1'b1;
                head_ent_d   = buf_q[0];
                buf_pop_s    = 1'b1;
                enq_to_buf_s = enq_s;
            end else if (enq_s) begin
                head_vld_d = 1'b1;
                head_ent_d = enq_ent_s;
            end else begin
                head_vld_d = 1'b0;
            end
        end else begin
            enq_to_buf_s = enq_s;
        end
        if (buf_pop_s) begin
            for (int i = 0; i < BUF_D - 1; i++) begin
                buf_d[i] = buf_q[i + 1];
            end
        end else begin
            buf_d = buf_q;
        end
        wr_idx_s = buf_cnt_q - CNT_W'(buf_pop_s);
        for (int i = 0; i < BUF_D; i++) begin
            buf_d[i] = (enq_to_buf_s && (wr_idx_s == CNT_W'(i))) ? enq_ent_s : buf_d[i];
        end
        buf_cnt_d = buf_cnt_q - CNT_W'(buf_pop_s) + CNT_W'(enq_to_buf_s);
    end

    // Clear sequencing FSM: drain outstanding work, strobe clear, wait for idle.
    always_comb begin
        state_d     = state_q;
        clear_ack_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (clear_req) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && !gap_q && !busy_r) begin
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_CLR: begin
                state_d = ST_WAITB;
            end
            ST_WAITB: begin
                if (!busy_r) begin
                    state_d     = ST_RUN;
                    clear_ack_d = 1'b1;
                end else begin
                    state_d = ST_WAITB;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        clear_d = (state_d == ST_CLR);
    end

    // State, FIFO and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            gap_q       <= 1'b0;
            inflight_q  <= 1'b0;
            clear_q     <= 1'b0;
            clear_ack_q <= 1'b0;
            head_vld_q  <= 1'b0;
            head_ent_q  <= '0;
            buf_cnt_q   <= '0;
            for (int i = 0; i < BUF_D; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            inflight_q  <= inflight_d;
            clear_q     <= clear_d;
            clear_ack_q <= clear_ack_d;
            head_vld_q  <= head_vld_d;
            head_ent_q  <= head_ent_d;
            buf_cnt_q   <= buf_cnt_d;
            buf_q       <= buf_d;
        end
    end

    assign in_rdy        = in_rdy_s;
    assign cmd_pass      = pass_s;
    assign cmd_op        = in_op;
    assign cmd_id        = in_id;
    assign cmd_push_data = in_data;
    assign rsp_vld       = head_vld_q;
    assign rsp_err       = head_ent_q[DATA_W];
    assign rsp_data      = head_ent_q[DATA_W-1:0];
    assign clear         = clear_q;
    assign clear_ack     = clear_ack_q;

endmodule

// File: tb/tb_dll_cmd_issue.sv
// Directed self-checking bench for dll_cmd_issue. The bench plays the list:
// it drives the status flags and returns pop data one cycle after a pop issue.
module tb_dll_cmd_issue;

    localparam logic [1:0] OP_POP_FRONT  = 2'b00;
    localparam logic [1:0] OP_PUSH_BACK  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic       in_rdy;
    logic [1:0] in_op;
    logic [1:0] in_id;
    logic [7:0] in_data;
    logic       rsp_vld;
    logic       rsp_rdy;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       clear_req;
    logic       clear_ack;
    logic       cmd_pass;
    logic [1:0] cmd_op;
    logic [1:0] cmd_id;
    logic [7:0] cmd_push_data;
    logic [7:0] pop_data_m = 8'h00;
    logic       pop_vld_m = 1'b0;
    logic       clear;
    logic       full_r;
    logic [3:0] nempty_r;
    logic       busy_r;
    logic [7:0] pop_ret;

    int total = 0;
    int bad   = 0;

    dll_cmd_issue #(.RSP_DEPTH(2), .OP_W(2), .ID_W(2), .DATA_W(8), .OP_PUSH_B(1)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_op(in_op), .in_id(in_id), .in_data(in_data),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .clear_req(clear_req), .clear_ack(clear_ack),
        .cmd_pass(cmd_pass), .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_push_data(cmd_push_data),
        .cmd_pop_data(pop_data_m), .cmd_pop_data_vld_r(pop_vld_m),
        .clear(clear), .full_r(full_r), .nempty_r(nempty_r), .busy_r(busy_r)
    );

    always #5 clk = ~clk;

    // List model: pop data returns one cycle after a pop is issued.
    always @(posedge clk) begin
        pop_vld_m <= cmd_pass && !cmd_op[1];
        if (cmd_pass) pop_data_m <= pop_ret;
    end

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b1; in_op = OP_PUSH_BACK; in_id = 2'd0; in_data = 8'h00;
        rsp_rdy = 1'b1; clear_req = 1'b0; full_r = 1'b0; nempty_r = 4'h0; busy_r = 1'b0;
        pop_ret = 8'h00;
        @(negedge clk); @(negedge clk); #1;
        total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL reset_in_rdy got=%b want=0", in_rdy); end
        total++; if (cmd_pass !== 1'b0) begin bad++; $display("FAIL reset_cmd_pass got=%b want=0", cmd_pass); end
        total++; if ({rsp_vld, rsp_err, rsp_data} !== 10'h000) begin bad++; $display("FAIL reset_rsp got=%b/%b/%h want=0/0/00", rsp_vld, rsp_err, rsp_data); end
        total++; if ({clear, clear_ack} !== 2'b00) begin bad++; $display("FAIL reset_clear got=%b%b want=00", clear, clear_ack); end
        @(negedge clk);
        rst = 1'b0; in_vld = 1'b0; #1;
        total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL post_reset_in_rdy got=%b want=1", in_rdy); end
    endtask

    task automatic test_push();
        in_vld = 1'b1; in_op = OP_PUSH_BACK; in_id = 2'd1; in_data = 8'hA5; rsp_rdy = 1'b1; #1;
        total++; if (cmd_pass !== 1'b1) begin bad++; $display("FAIL push_pass got=%b want=1", cmd_pass); end
        total++; if ({cmd_op, cmd_id, cmd_push_data} !== {OP_PUSH_BACK, 2'd1, 8'hA5}) begin bad++; $display("FAIL push_cmd got=%b/%h/%h want=11/1/a5", cmd_op, cmd_id, cmd_push_data); end
        total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL push_rsp_early got=%b want=0", rsp_vld); end
        @(negedge clk);
        in_vld = 1'b0; #1;
        total++; if ({rsp_vld, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h00}) begin bad++; $display("FAIL push_rsp got=%b/%b/%h want=1/0/00", rsp_vld, rsp_err, rsp_data); end
        total++; if ({cmd_pass, in_rdy} !== 2'b00) begin bad++; $display("FAIL push_gap got=%b%b want=00", cmd_pass, in_rdy); end
        nempty_r[1] = 1'b1;
        @(negedge clk); #1;
        total++; if ({rsp_vld, in_rdy} !== 2'b01) begin bad++; $display("FAIL push_after got=%b%b want=01", rsp_vld, in_rdy); end
        @(negedge clk);
    endtask

    task automatic test_pop();
        pop_ret = 8'hA5; in_vld = 1'b1; in_op = OP_POP_FRONT; in_id = 2'd1; #1;
        total++; if (cmd_pass !== 1'b1) begin bad++; $display("FAIL pop_pass got=%b want=1", cmd_pass); end
        @(negedge clk);
        in_vld = 1'b0; #1;
        total++; if ({pop_vld_m, rsp_vld, in_rdy} !== 3'b100) begin bad++; $display("FAIL pop_plus1 got=%b%b%b want=100", pop_vld_m, rsp_vld, in_rdy); end
        @(negedge clk); #1;
        total++; if ({rsp_vld, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'hA5}) begin bad++; $display("FAIL pop_rsp got=%b/%b/%h want=1/0/a5", rsp_vld, rsp_err, rsp_data); end
        total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL pop_rdy got=%b want=1", in_rdy); end
        nempty_r[1] = 1'b0;
        @(negedge clk); #1;
        total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL pop_drained got=%b want=0", rsp_vld); end
    endtask

    task automatic test_reject();
        in_vld = 1'b1; in_op = OP_POP_FRONT; in_id = 2'd3; #1;
        total++; if ({in_rdy, cmd_pass} !== 2'b10) begin bad++; $display("FAIL rej_pop_issue got=%b%b want=10", in_rdy, cmd_pass); end
        @(negedge clk);
        in_op = OP_PUSH_BACK; in_id = 2'd0; in_data = 8'h3C; full_r = 1'b1; #1;
        total++; if ({rsp_vld, rsp_err, rsp_data} !== {1'b1, 1'b1, 8'h00}) begin bad++; $display("FAIL rej_pop_rsp got=%b/%b/%h want=1/1/00", rsp_vld, rsp_err, rsp_data); end
        total++; if ({in_rdy, cmd_pass} !== 2'b10) begin bad++; $display("FAIL rej_push_issue got=%b%b want=10", in_rdy, cmd_pass); end
        @(negedge clk);
        in_vld = 1'b0; full_r = 1'b0; #1;
        total++; if ({rsp_vld, rsp_err, rsp_data} !== {1'b1, 1'b1, 8'h00}) begin bad++; $display("FAIL rej_push_rsp got=%b/%b/%h want=1/1/00", rsp_vld, rsp_err, rsp_data); end
        @(negedge clk); #1;
        total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL rej_drained got=%b want=0", rsp_vld); end
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        int ngot = 0;
        logic [7:0] got [4];
        nempty_r[2] = 1'b1; in_op = OP_POP_FRONT; in_id = 2'd2;
        for (int cyc = 0; cyc < 40 && ngot < 4; cyc++) begin
            rsp_rdy = (cyc >= 10);
            in_vld  = (issued < 4);
            pop_ret = 8'h10 + 8'(issued);
            #1;
            if (cyc == 9) begin
                total++; if (issued !== 2) begin bad++; $display("FAIL b2b_issued got=%0d want=2", issued); end
                total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b want=0", in_rdy); end
                total++; if ({rsp_vld, rsp_data} !== {1'b1, 8'h10}) begin bad++; $display("FAIL b2b_head got=%b/%h want=1/10", rsp_vld, rsp_data); end
            end
            if (cmd_pass) issued++;
            if (rsp_vld && rsp_rdy) begin
                got[ngot] = rsp_data;
                ngot++;
            end
            @(negedge clk);
        end
        in_vld = 1'b0;
        total++; if (ngot !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", ngot); end
        for (int i = 0; i < ngot; i++) begin
            total++; if (got[i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL b2b_order[%0d] got=%h want=%h", i, got[i], 8'h10 + 8'(i)); end
        end
        @(negedge clk); #1;
        total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b want=0", rsp_vld); end
        @(negedge clk);
    endtask

    task automatic test_clear();
        rsp_rdy = 1'b1; pop_ret = 8'h77; in_vld = 1'b1; in_op = OP_POP_FRONT; in_id = 2'd2; #1;
        total++; if (cmd_pass !== 1'b1) begin bad++; $display("FAIL clr_pop_pass got=%b want=1", cmd_pass); end
        @(negedge clk);
        in_vld = 1'b0; clear_req = 1'b1; #1;
        total++; if ({in_rdy, clear} !== 2'b00) begin bad++; $display("FAIL clr_n1 got=%b%b want=00", in_rdy, clear); end
        @(negedge clk); #1;
        total++; if ({rsp_vld, rsp_data, clear} !== {1'b1, 8'h77, 1'b0}) begin bad++; $display("FAIL clr_n2 got=%b/%h/%b want=1/77/0", rsp_vld, rsp_data, clear); end
        @(negedge clk); #1;
        total++; if (clear !== 1'b1) begin bad++; $display("FAIL clr_strobe got=%b want=1", clear); end
        busy_r = 1'b1;
        @(negedge clk); #1;
        total++; if ({clear, clear_ack} !== 2'b00) begin bad++; $display("FAIL clr_waitb got=%b%b want=00", clear, clear_ack); end
        @(negedge clk);
        busy_r = 1'b0; #1;
        total++; if (clear_ack !== 1'b0) begin bad++; $display("FAIL clr_ack_early got=%b want=0", clear_ack); end
        @(negedge clk); #1;
        total++; if (clear_ack !== 1'b1) begin bad++; $display("FAIL clr_ack got=%b want=1", clear_ack); end
        clear_req = 1'b0;
        @(negedge clk); #1;
        total++; if ({clear_ack, clear, in_rdy} !== 3'b001) begin bad++; $display("FAIL clr_done got=%b%b%b want=001", clear_ack, clear, in_rdy); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rsp_rdy = 1'b0; in_vld = 1'b1; in_op = OP_POP_FRONT; in_id = 2'd3;
        @(negedge clk);
        in_id = 2'd2; pop_ret = 8'hEE; #1;
        total++; if ({rsp_vld, cmd_pass} !== 2'b11) begin bad++; $display("FAIL rm_setup got=%b%b want=11", rsp_vld, cmd_pass); end
        @(negedge clk);
        in_vld = 1'b0; rst = 1'b1; #1;
        total++; if ({rsp_vld, in_rdy} !== 2'b00) begin bad++; $display("FAIL rm_reset got=%b%b want=00", rsp_vld, in_rdy); end
        @(negedge clk);
        rst = 1'b0; rsp_rdy = 1'b1; in_vld = 1'b1; in_op = OP_PUSH_BACK; in_id = 2'd0; in_data = 8'h5A; #1;
        total++; if ({rsp_vld, in_rdy, cmd_pass} !== 3'b011) begin bad++; $display("FAIL rm_resume got=%b%b%b want=011", rsp_vld, in_rdy, cmd_pass); end
        @(negedge clk);
        in_vld = 1'b0; #1;
        total++; if ({rsp_vld, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h00}) begin bad++; $display("FAIL rm_push_rsp got=%b/%b/%h want=1/0/00", rsp_vld, rsp_err, rsp_data); end
        @(negedge clk); #1;
        total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL rm_no_stale got=%b want=0", rsp_vld); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop();
        test_reject();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completing");
        $fatal(1, "timeout");
    end

endmodule
